gfx_cfg_scheduler: RTL and testbench

Arbitrates access to the graphics core's configuration register bank between two requesters: the Wishbone slave port (management CPU) and the logic-analyzer port (LA request bus). All writes land in a shadow bank. A sequencer copies the shadow bank into the active bank, one word per cycle, at the start of vertical blanking, so the raster never sees a half-updated configuration. The block sits between the user-project wrapper buses and the VGA pipeline's configuration inputs.

---
 rtl/gfx_cfg_scheduler.sv | 148 ++++++++++++++
 tb/tb_gfx_cfg_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_cfg_scheduler.sv
// Configuration register scheduler: WB/LA round-robin access to a shadow bank,
// copied word-by-word into the active bank on a vertical-blank rising edge.
module gfx_cfg_scheduler #(
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              la_req_i,
    input  logic              la_we_i,
    input  logic [ADDR_W-1:0] la_adr_i,
    input  logic [31:0]       la_dat_i,
    output logic              la_gnt_o,
    output logic [31:0]       la_dat_o,
    input  logic              vblank_i,
    input  logic [ADDR_W-1:0] cfg_rd_adr_i,
    output logic [31:0]       cfg_rd_dat_o,
    output logic              commit_o,
    output logic              dirty_o
);

    localparam int          WORDS = 1 << ADDR_W;
    localparam logic [31:0] SPAN  = 32'(4 * WORDS);

    typedef enum logic {IDLE, COPY} state_t;

    state_t            state, state_nx;
    logic [31:0]       shadow [WORDS];
    logic [31:0]       active [WORDS];
    logic [ADDR_W-1:0] copy_idx;
    logic [ADDR_W-1:0] wb_idx;
    logic [31:0]       wb_off;
    logic              vblank_q;
    logic              last_la;
    logic              wb_hit, la_hit;
    logic              gnt_wb, gnt_la;
    logic              wb_write, la_write;
    logic              vblank_rise, copy_last;

    // Offset subtraction wraps below BASE_ADDR, so one unsigned compare covers both bounds.
    always_comb begin
        wb_off      = wbs_adr_i - BASE_ADDR;
        wb_idx      = wbs_adr_i[ADDR_W+1:2];
        wb_hit      = wbs_cyc_i & wbs_stb_i & (wb_off < SPAN) & ~wbs_ack_o;
        la_hit      = la_req_i & ~la_gnt_o;
        vblank_rise = vblank_i & ~vblank_q;
        copy_last   = &copy_idx;
    end

    always_comb begin
        state_nx = state;
        gnt_wb   = 1'b0;
        gnt_la   = 1'b0;
        wb_write = 1'b0;
        la_write = 1'b0;
        case (state)
            IDLE: begin
                gnt_wb   = wb_hit & (~la_hit | last_la);
                gnt_la   = la_hit & (~wb_hit | ~last_la);
                wb_write = gnt_wb & wbs_we_i;
                la_write = gnt_la & la_we_i;
                if (vblank_rise && (dirty_o || wb_write || la_write))
                    state_nx = COPY;
            end
            COPY: begin
                if (copy_last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Reset value of last_la makes the first contested grant go to WB.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            vblank_q  <= 1'b0;
            last_la   <= 1'b1;
            dirty_o   <= 1'b0;
            commit_o  <= 1'b0;
            copy_idx  <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            la_gnt_o  <= 1'b0;
            la_dat_o  <= '0;
        end else begin
            vblank_q  <= vblank_i;
            commit_o  <= (state == COPY) && copy_last;
            copy_idx  <= (state == COPY) ? copy_idx + ADDR_W'(1) : '0;
            wbs_ack_o <= gnt_wb;
            wbs_dat_o <= (gnt_wb && !wbs_we_i) ? shadow[wb_idx] : '0;
            la_gnt_o  <= gnt_la;
            la_dat_o  <= (gnt_la && !la_we_i) ? shadow[la_adr_i] : '0;
            if (gnt_la)
                last_la <= 1'b1;
            else if (gnt_wb)
                last_la <= 1'b0;
            if ((state == COPY) && copy_last)
                dirty_o <= 1'b0;
            else if (wb_write || la_write)
                dirty_o <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < WORDS; i++)
                shadow[i] <= '0;
        end else if (wb_write) begin
            for (int b = 0; b < 4; b++)
                if (wbs_sel_i[b])
                    shadow[wb_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end else if (la_write) begin
            shadow[la_adr_i] <= la_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < WORDS; i++)
                active[i] <= '0;
        end else if (state == COPY) begin
            active[copy_idx] <= shadow[copy_idx];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            cfg_rd_dat_o <= '0;
        else
            cfg_rd_dat_o <= active[cfg_rd_adr_i];
    end

endmodule

// File: tb/tb_gfx_cfg_scheduler.sv
// Directed bench for gfx_cfg_scheduler; responses are checked by a scoreboard
// monitor that pops expected WB/LA completions in arrival order.
module tb_gfx_cfg_scheduler;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        la_req_i = 1'b0, la_we_i = 1'b0;
    logic [3:0]  la_adr_i = '0;
    logic [31:0] la_dat_i = '0;
    logic        la_gnt_o;
    logic [31:0] la_dat_o;
    logic        vblank_i = 1'b0;
    logic [3:0]  cfg_rd_adr_i = '0;
    logic [31:0] cfg_rd_dat_o;
    logic        commit_o, dirty_o;

    typedef struct {
        logic        is_la;
        logic        check_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    gfx_cfg_scheduler #(.ADDR_W(4), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .la_req_i(la_req_i), .la_we_i(la_we_i), .la_adr_i(la_adr_i),
        .la_dat_i(la_dat_i), .la_gnt_o(la_gnt_o), .la_dat_o(la_dat_o),
        .vblank_i(vblank_i), .cfg_rd_adr_i(cfg_rd_adr_i), .cfg_rd_dat_o(cfg_rd_dat_o),
        .commit_o(commit_o), .dirty_o(dirty_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor samples on the falling edge, half a cycle away from the active edge.
    always @(negedge wb_clk_i) begin
        if (wb_rst_ni && (wbs_ack_o || la_gnt_o)) begin
            exp_t e;
            check_output("ack_gnt_exclusive", {31'b0, wbs_ack_o & la_gnt_o}, 32'd0);
            if (sb_q.size() == 0) begin
                check_output("unexpected_response", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_output("resp_src", {31'b0, la_gnt_o}, {31'b0, e.is_la});
                if (e.check_data)
                    check_output("resp_data", la_gnt_o ? la_dat_o : wbs_dat_o, e.data);
            end
        end
    end

    task automatic apply_stimulus_wb(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                                     input logic [31:0] dat, input logic [31:0] exp_dat);
        int lat = 0;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
        sb_q.push_back('{1'b0, !we, exp_dat});
        for (int i = 1; i <= 40; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin
                lat = i;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        check_output("wb_latency", lat, 32'd1);
    endtask

    task automatic apply_stimulus_la(input logic [3:0] adr, input logic we,
                                     input logic [31:0] dat, input logic [31:0] exp_dat);
        int lat = 0;
        @(negedge wb_clk_i);
        la_req_i = 1'b1; la_we_i = we; la_adr_i = adr; la_dat_i = dat;
        sb_q.push_back('{1'b1, !we, exp_dat});
        for (int i = 1; i <= 40; i++) begin
            @(negedge wb_clk_i);
            if (la_gnt_o) begin
                lat = i;
                break;
            end
        end
        la_req_i = 1'b0; la_we_i = 1'b0;
        check_output("la_latency", lat, 32'd1);
    endtask

    // WB and LA raise requests together; WB is expected first because LA won last.
    task automatic apply_stimulus_both(input logic [31:0] wb_adr, input logic [31:0] wb_exp,
                                       input logic [3:0] la_adr, input logic [31:0] la_exp);
        logic wb_done = 1'b0, la_done = 1'b0;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = wb_adr;
        la_req_i = 1'b1; la_we_i = 1'b0; la_adr_i = la_adr;
        sb_q.push_back('{1'b0, 1'b1, wb_exp});
        sb_q.push_back('{1'b1, 1'b1, la_exp});
        for (int i = 1; i <= 10; i++) begin
            @(negedge wb_clk_i);
            if (!wb_done && wbs_ack_o) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wb_done = 1'b1;
            end
            if (!la_done && la_gnt_o) begin
                la_req_i = 1'b0; la_done = 1'b1;
            end
            if (wb_done && la_done) break;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; la_req_i = 1'b0;
        check_output("rr_both_done", {30'b0, wb_done, la_done}, 32'd3);
    endtask

    task automatic check_cfg(input logic [3:0] adr, input logic [31:0] expected, input string name);
        @(negedge wb_clk_i);
        cfg_rd_adr_i = adr;
        @(negedge wb_clk_i);
        check_output(name, cfg_rd_dat_o, expected);
    endtask

    task automatic pulse_vblank(input int window, output int commit_at, output int commits);
        commit_at = 0;
        commits = 0;
        @(negedge wb_clk_i);
        vblank_i = 1'b1;
        for (int i = 1; i <= window; i++) begin
            @(negedge wb_clk_i);
            if (i == 1) vblank_i = 1'b0;
            if (commit_o) begin
                commits++;
                if (commit_at == 0) commit_at = i;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ack"},    {31'b0, wbs_ack_o}, 32'd0);
        check_output({tag, "_wbdat"},  wbs_dat_o, 32'd0);
        check_output({tag, "_gnt"},    {31'b0, la_gnt_o}, 32'd0);
        check_output({tag, "_ladat"},  la_dat_o, 32'd0);
        check_output({tag, "_commit"}, {31'b0, commit_o}, 32'd0);
        check_output({tag, "_dirty"},  {31'b0, dirty_o}, 32'd0);
        check_output({tag, "_cfgdat"}, cfg_rd_dat_o, 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int commit_at, commits, gnt_at, acks;

        repeat (3) @(negedge wb_clk_i);
        check_all_zero("reset");
        wb_rst_ni = 1'b1;

        // Write lands in shadow only; active stays 0 until a vblank commit.
        apply_stimulus_wb(BASE + 32'h8, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0);
        check_output("dirty_after_write", {31'b0, dirty_o}, 32'd1);
        apply_stimulus_wb(BASE + 32'h8, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF);
        check_cfg(4'd2, 32'h0, "cfg2_precommit");

        pulse_vblank(30, commit_at, commits);
        check_output("commit_latency", commit_at, 32'd17);
        check_output("commit_count", commits, 32'd1);
        check_output("dirty_after_commit", {31'b0, dirty_o}, 32'd0);
        check_cfg(4'd2, 32'hDEAD_BEEF, "cfg2_committed");

        apply_stimulus_la(4'd3, 1'b1, 32'h1122_3344, 32'h0);
        for (int r = 0; r < 4; r++)
            apply_stimulus_both(BASE + 32'h8, 32'hDEAD_BEEF, 4'd3, 32'h1122_3344);

        apply_stimulus_wb(BASE + 32'hC, 1'b1, 4'b0010, 32'h0000_AB00, 32'h0);
        apply_stimulus_la(4'd3, 1'b0, 32'h0, 32'h1122_AB44);

        // LA write raised two cycles into COPY must wait for the first IDLE cycle.
        commit_at = 0; gnt_at = 0;
        @(negedge wb_clk_i);
        vblank_i = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge wb_clk_i);
            if (i == 1) vblank_i = 1'b0;
            if (i == 2) begin
                la_req_i = 1'b1; la_we_i = 1'b1; la_adr_i = 4'd5; la_dat_i = 32'hCAFE_F00D;
                sb_q.push_back('{1'b1, 1'b0, 32'h0});
            end
            if (commit_o && commit_at == 0) commit_at = i;
            if (la_gnt_o && gnt_at == 0) begin
                gnt_at = i;
                la_req_i = 1'b0; la_we_i = 1'b0;
            end
        end
        la_req_i = 1'b0;
        check_output("copy2_commit", commit_at, 32'd17);
        check_output("stalled_la_gnt", gnt_at, 32'd18);
        check_output("dirty_after_stalled", {31'b0, dirty_o}, 32'd1);
        check_cfg(4'd3, 32'h1122_AB44, "cfg3_committed");
        check_cfg(4'd5, 32'h0, "cfg5_pending");

        pulse_vblank(30, commit_at, commits);
        check_output("copy3_commit", commit_at, 32'd17);
        check_cfg(4'd5, 32'hCAFE_F00D, "cfg5_committed");

        pulse_vblank(25, commit_at, commits);
        check_output("clean_vblank_commits", commits, 32'd0);
        apply_stimulus_wb(BASE + 32'h14, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D);

        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h40;
        acks = 0;
        repeat (20) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check_output("oor_no_ack", acks, 32'd0);

        apply_stimulus_wb(BASE + 32'h4, 1'b1, 4'hF, 32'h55AA_55AA, 32'h0);
        check_cfg(4'd5, 32'hCAFE_F00D, "cfg5_pre_reset");
        @(negedge wb_clk_i);
        vblank_i = 1'b1;
        @(negedge wb_clk_i);
        vblank_i = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        #2 wb_rst_ni = 1'b0;
        #1 check_all_zero("midcopy_reset");
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        check_cfg(4'd5, 32'h0, "cfg5_after_reset");
        check_cfg(4'd1, 32'h0, "cfg1_after_reset");
        apply_stimulus_wb(BASE + 32'h8, 1'b0, 4'hF, 32'h0, 32'h0);

        repeat (3) @(negedge wb_clk_i);
        check_output("scoreboard_drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
